// File: rtl/pulse_acq_pkg.sv
// Shared types and constants for the pulse report framer.
// Macro PULSE_REPORT_CKSUM_EN appends a checksum byte and makes the frame 12 bytes long instead of 11.
package pulse_acq_pkg;
  localparam logic [7:0] HDR0_DEF = 8'hA5;
  localparam logic [7:0] HDR1_DEF = 8'h5A;
`ifdef PULSE_REPORT_CKSUM_EN
  localparam int FRAME_LEN = 12;
`else
  localparam int FRAME_LEN = 11;
`endif
  localparam int IDX_W = 4;
  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
endpackage

// File: rtl/pulse_report_framer_if.sv
// Groups the measurement input strobe and the TX FIFO write port.
// The framer uses the slave view. The measurement source and the FIFO use the master view.
interface pulse_report_framer_if #(parameter int USEDW_W = 8);
  logic [31:0]        period;
  logic [31:0]        width;
  logic               meas_valid;
  logic               tx_fifo_wen;
  logic [7:0]         tx_fifo_wdata;
  logic               tx_fifo_full;
  logic [USEDW_W-1:0] tx_fifo_usedw;

  modport slave (
    input  period, width, meas_valid, tx_fifo_full, tx_fifo_usedw,
    output tx_fifo_wen, tx_fifo_wdata
  );
  modport master (
    output period, width, meas_valid, tx_fifo_full, tx_fifo_usedw,
    input  tx_fifo_wen, tx_fifo_wdata
  );
endinterface

// File: rtl/pulse_frame_byte_sel.sv
// Combinational mux: byte index -> frame byte (header, seq, big-endian period/width, cksum).
module pulse_frame_byte_sel
  import pulse_acq_pkg::*;
#(
  parameter logic [7:0] HDR0 = HDR0_DEF,
  parameter logic [7:0] HDR1 = HDR1_DEF
) (
  input  idx_t        idx,
  input  logic [7:0]  seq,
  input  logic [31:0] period,
  input  logic [31:0] width,
  input  logic [7:0]  cksum,
  output logic [7:0]  dat
);
  always_comb begin
    dat = 8'h00;
    case (idx)
      4'd0:    dat = HDR0;
      4'd1:    dat = HDR1;
      4'd2:    dat = seq;
      4'd3:    dat = period[31:24];
      4'd4:    dat = period[23:16];
      4'd5:    dat = period[15:8];
      4'd6:    dat = period[7:0];
      4'd7:    dat = width[31:24];
      4'd8:    dat = width[23:16];
      4'd9:    dat = width[15:8];
      4'd10:   dat = width[7:0];
      4'd11:   dat = cksum;
      default: dat = 8'h00;
    endcase
  end
endmodule

// File: rtl/pulse_report_framer.sv
// Packs each measurement into a fixed-length frame and writes it to the UART TX FIFO.
// A frame starts only if the FIFO has room for all of it. Define PULSE_REPORT_CKSUM_EN to append the cksum byte.
module pulse_report_framer
  import pulse_acq_pkg::*;
#(
  parameter int         FIFO_DEPTH = 256,
  parameter int         USEDW_W    = 8,
  parameter logic [7:0] HDR0       = HDR0_DEF,
  parameter logic [7:0] HDR1       = HDR1_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  pulse_report_framer_if.slave        bus,
  output logic                        busy,
  output logic [15:0]                 frame_cnt,
  output logic [15:0]                 drop_cnt
);
  localparam int START_MAX = FIFO_DEPTH - FRAME_LEN;

  state_t             state, state_n;
  idx_t               idx, idx_n, sel_idx;
  logic               pending, start, emit, frame_done;
  logic [31:0]        p_per, p_wid, s_per, s_wid;
  logic [7:0]         seq, cksum, byte_dat;
  logic [USEDW_W-1:0] usedw;

  assign usedw      = bus.tx_fifo_usedw;
  assign start      = (state == IDLE) && pending && ena && (int'(usedw) <= START_MAX);
  assign frame_done = (state == SEND) && (state_n == GAP);
  assign busy       = (state != IDLE);

  pulse_frame_byte_sel #(.HDR0(HDR0), .HDR1(HDR1)) u_byte_sel (
    .idx    (sel_idx),
    .seq    (seq),
    .period (s_per),
    .width  (s_wid),
    .cksum  (cksum),
    .dat    (byte_dat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // The first byte leaves on the IDLE->SEND edge, so idx always names the next byte to send.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    sel_idx = idx;
    emit    = 1'b0;
    case (state)
      IDLE: begin
        idx_n = '0;
        if (start) begin
          state_n = SEND;
          sel_idx = '0;
          emit    = !bus.tx_fifo_full;
          idx_n   = emit ? idx_t'(1) : idx_t'(0);
        end
      end
      SEND: begin
        if (idx == idx_t'(FRAME_LEN)) begin
          state_n = GAP;
        end else begin
          emit  = !bus.tx_fifo_full;
          idx_n = emit ? idx + idx_t'(1) : idx;
        end
      end
      GAP: begin
        state_n = IDLE;
        idx_n   = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.tx_fifo_wen   <= 1'b0;
      bus.tx_fifo_wdata <= 8'h00;
      pending           <= 1'b0;
      p_per             <= '0;
      p_wid             <= '0;
      s_per             <= '0;
      s_wid             <= '0;
      seq               <= 8'h00;
      frame_cnt         <= 16'h0000;
      drop_cnt          <= 16'h0000;
    end else begin
      bus.tx_fifo_wen   <= emit;
      bus.tx_fifo_wdata <= emit ? byte_dat : 8'h00;
      if (start) begin
        s_per <= p_per;
        s_wid <= p_wid;
      end
      if (bus.meas_valid) begin
        p_per <= bus.period;
        p_wid <= bus.width;
      end
      // A strobe in the same cycle as the shadow copy refills pending without counting a drop.
      pending <= bus.meas_valid | (pending & ~start);
      if (bus.meas_valid && pending && !start && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'h0001;
      if (frame_done) begin
        frame_cnt <= frame_cnt + 16'h0001;
        seq       <= seq + 8'h01;
      end
    end
  end

`ifdef PULSE_REPORT_CKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cksum <= 8'h00;
    else if (start)
      cksum <= 8'h00;
    else if (emit && state == SEND && idx >= idx_t'(2) && idx <= idx_t'(FRAME_LEN-2))
      cksum <= cksum + byte_dat;
  end
`else
  assign cksum = 8'h00;
`endif
endmodule

// File: tb/tb_pulse_report_framer.sv
// Self-checking bench for pulse_report_framer: a scoreboard of expected frame bytes, a vector table and corner-case sequences.
module tb_pulse_report_framer;
  import pulse_acq_pkg::*;

  localparam int FIFO_DEPTH = 256;
  localparam int USEDW_W    = 8;

  typedef struct {
    logic [31:0] period;
    logic [31:0] width;
    logic [15:0] exp_frames;
    logic [15:0] exp_drops;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b0;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic [7:0] seq_m  = 8'h00;
  logic [7:0] exp_q[$];
  int         wen_cyc_q[$];

  pulse_report_framer_if #(.USEDW_W(USEDW_W)) bus ();

  pulse_report_framer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .USEDW_W    (USEDW_W),
    .HDR0       (8'hA5),
    .HDR1       (8'h5A)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .bus       (bus.slave),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every written byte must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst && bus.tx_fifo_wen) begin
      wen_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wen: got byte %0h expected no write (cycle %0d)", bus.tx_fifo_wdata, cyc);
      end else begin
        check("frame_byte", {24'h0, bus.tx_fifo_wdata}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_meas(input logic [31:0] p, input logic [31:0] w);
    bus.period     = p;
    bus.width      = w;
    bus.meas_valid = 1'b1;
    tick(1);
    bus.meas_valid = 1'b0;
  endtask

  task automatic push_frame(input logic [31:0] p, input logic [31:0] w);
    logic [7:0] b[FRAME_LEN];
`ifdef PULSE_REPORT_CKSUM_EN
    logic [7:0] sum;
`endif
    b[0] = 8'hA5;
    b[1] = 8'h5A;
    b[2] = seq_m;
    for (int i = 0; i < 4; i++) begin
      b[3+i] = p[31-8*i -: 8];
      b[7+i] = w[31-8*i -: 8];
    end
`ifdef PULSE_REPORT_CKSUM_EN
    sum = 8'h00;
    for (int i = 2; i < 11; i++) sum = sum + b[i];
    b[11] = sum;
`endif
    for (int i = 0; i < FRAME_LEN; i++) exp_q.push_back(b[i]);
    seq_m = seq_m + 8'h01;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || busy) && n < budget);
    if (exp_q.size() != 0 || busy) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d bytes outstanding expected 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    vec_t       vecs[4];
    logic [7:0] golden[12];
    int         t0;
    int         t1;

    golden = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h98, 8'h96, 8'h80, 8'h00, 8'h4C, 8'h4B, 8'h40, 8'h85};
    vecs[0] = '{32'hFFFFFFFF, 32'h00000000, 16'd2, 16'd0};
    vecs[1] = '{32'h12345678, 32'h9ABCDEF0, 16'd3, 16'd0};
    vecs[2] = '{32'h00000001, 32'h00000001, 16'd4, 16'd0};
    vecs[3] = '{32'hDEADBEEF, 32'hCAFEF00D, 16'd5, 16'd0};

    bus.period        = '0;
    bus.width         = '0;
    bus.meas_valid    = 1'b0;
    bus.tx_fifo_full  = 1'b0;
    bus.tx_fifo_usedw = '0;

    tick(3);
    check("rst_wen", {31'h0, bus.tx_fifo_wen}, 32'h0);
    check("rst_wdata", {24'h0, bus.tx_fifo_wdata}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_frame_cnt", {16'h0, frame_cnt}, 32'h0);
    check("rst_drop_cnt", {16'h0, drop_cnt}, 32'h0);
    rst = 1'b1;
    ena = 1'b1;
    tick(2);

    // Reference frame with exact timing.
    for (int i = 0; i < FRAME_LEN; i++) exp_q.push_back(golden[i]);
    seq_m = 8'h01;
    wen_cyc_q.delete();
    t0 = cyc;
    pulse_meas(32'h00989680, 32'h004C4B40);
    while (cyc < t0 + FRAME_LEN + 2) @(negedge clk);
    check("gap_busy", {31'h0, busy}, 32'h1);
    check("frame_cnt_1", {16'h0, frame_cnt}, 32'h1);
    @(negedge clk);
    check("idle_after_gap", {31'h0, busy}, 32'h0);
    check("s1_bytes_left", exp_q.size(), 0);
    check("s1_wen_count", wen_cyc_q.size(), FRAME_LEN);
    check("s1_first_wen", wen_cyc_q[0], t0 + 2);
    check("s1_last_wen", wen_cyc_q[wen_cyc_q.size()-1], t0 + FRAME_LEN + 1);
    exp_q.delete();

    for (int i = 0; i < 4; i++) begin
      push_frame(vecs[i].period, vecs[i].width);
      pulse_meas(vecs[i].period, vecs[i].width);
      wait_done("vec", 60);
      check("vec_frame_cnt", {16'h0, frame_cnt}, {16'h0, vecs[i].exp_frames});
      check("vec_drop_cnt", {16'h0, drop_cnt}, {16'h0, vecs[i].exp_drops});
    end

    // Three strobes two cycles apart: the middle one is overwritten.
    tick(1);
    push_frame(32'h11111111, 32'h22222222);
    push_frame(32'h55555555, 32'h66666666);
    pulse_meas(32'h11111111, 32'h22222222);
    tick(1);
    pulse_meas(32'h33333333, 32'h44444444);
    tick(1);
    pulse_meas(32'h55555555, 32'h66666666);
    wait_done("b2b", 80);
    check("b2b_frame_cnt", {16'h0, frame_cnt}, 32'd7);
    check("b2b_drop_cnt", {16'h0, drop_cnt}, 32'd1);

    // A strobe in the start cycle refills pending without a drop.
    tick(1);
    push_frame(32'hA0A0A0A0, 32'h0B0B0B0B);
    push_frame(32'hC0C0C0C0, 32'h0D0D0D0D);
    pulse_meas(32'hA0A0A0A0, 32'h0B0B0B0B);
    pulse_meas(32'hC0C0C0C0, 32'h0D0D0D0D);
    wait_done("coincident", 80);
    check("coinc_frame_cnt", {16'h0, frame_cnt}, 32'd9);
    check("coinc_drop_cnt", {16'h0, drop_cnt}, 32'd1);

    // FIFO one byte short of room: no start until usedw drops.
    tick(1);
    bus.tx_fifo_usedw = USEDW_W'(FIFO_DEPTH - FRAME_LEN + 1);
    pulse_meas(32'h0F0F0F0F, 32'hF0F0F0F0);
    wen_cyc_q.delete();
    tick(20);
    check("nearfull_no_wen", wen_cyc_q.size(), 0);
    check("nearfull_idle", {31'h0, busy}, 32'h0);
    push_frame(32'h0F0F0F0F, 32'hF0F0F0F0);
    bus.tx_fifo_usedw = USEDW_W'(FIFO_DEPTH - FRAME_LEN);
    t0 = cyc;
    wait_done("nearfull", 60);
    check("nearfull_start", wen_cyc_q[0], t0 + 1);
    check("nearfull_frame_cnt", {16'h0, frame_cnt}, 32'd10);
    bus.tx_fifo_usedw = '0;

    // Full flag for three cycles when byte 5 is next.
    tick(1);
    push_frame(32'h01234567, 32'h89ABCDEF);
    wen_cyc_q.delete();
    t0 = cyc;
    pulse_meas(32'h01234567, 32'h89ABCDEF);
    while (cyc != t0 + 6) tick(1);
    bus.tx_fifo_full = 1'b1;
    tick(3);
    bus.tx_fifo_full = 1'b0;
    wait_done("stall", 60);
    check("stall_wen_count", wen_cyc_q.size(), FRAME_LEN);
    check("stall_byte4_cyc", wen_cyc_q[4], t0 + 6);
    check("stall_byte5_cyc", wen_cyc_q[5], t0 + 10);
    check("stall_last_cyc", wen_cyc_q[wen_cyc_q.size()-1], t0 + FRAME_LEN + 4);

    // ena dropped mid-frame: current frame finishes, next waits for ena.
    tick(1);
    push_frame(32'h00000100, 32'h00000080);
    pulse_meas(32'h00000100, 32'h00000080);
    tick(4);
    ena = 1'b0;
    pulse_meas(32'h00000200, 32'h00000040);
    tick(30);
    check("ena_frame_done", exp_q.size(), 0);
    check("ena_frame_cnt", {16'h0, frame_cnt}, 32'd12);
    check("ena_hold_idle", {31'h0, busy}, 32'h0);
    wen_cyc_q.delete();
    push_frame(32'h00000200, 32'h00000040);
    t1 = cyc;
    ena = 1'b1;
    wait_done("ena_resume", 60);
    check("ena_resume_start", wen_cyc_q[0], t1 + 1);
    check("ena_drop_cnt", {16'h0, drop_cnt}, 32'd1);

    // Reset mid-frame aborts immediately; seq restarts at 0.
    tick(1);
    push_frame(32'h77777777, 32'h88888888);
    t0 = cyc;
    pulse_meas(32'h77777777, 32'h88888888);
    while (cyc != t0 + 5) tick(1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_mid_wen", {31'h0, bus.tx_fifo_wen}, 32'h0);
    check("rst_mid_frame_cnt", {16'h0, frame_cnt}, 32'h0);
    check("rst_mid_drop_cnt", {16'h0, drop_cnt}, 32'h0);
    check("rst_mid_busy", {31'h0, busy}, 32'h0);
    check("rst_mid_bytes_left", exp_q.size(), FRAME_LEN - 4);
    exp_q.delete();
    seq_m = 8'h00;
    tick(2);
    rst = 1'b1;
    tick(1);
    push_frame(32'h00989680, 32'h004C4B40);
    pulse_meas(32'h00989680, 32'h004C4B40);
    wait_done("post_rst", 60);
    check("post_rst_frame_cnt", {16'h0, frame_cnt}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pulse_report_framer.md
# pulse_report_framer

Downstream consumer of the pulse period/width measurement stage. Each completed measurement (32-bit period, 32-bit width, single-cycle valid strobe) is packed into a fixed-length byte frame and written into the UART TX FIFO. Frames are never split: a frame starts only when the FIFO has room for all of it. One measurement is held pending while a frame is in flight, and overwritten measurements are counted.

## Interface
Parameters:
- FIFO_DEPTH, 256, TX FIFO depth in bytes
- USEDW_W, 8, width of tx_fifo_usedw
- HDR0, 8'hA5, first header byte
- HDR1, 8'h5A, second header byte

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- ena  in  1  frame start enable
- period  in  32  measured period, in count ticks
- width  in  32  measured high width, in count ticks
- meas_valid  in  1  one-cycle strobe; period/width are valid in the same cycle
- tx_fifo_wen  out  1  FIFO write strobe
- tx_fifo_wdata  out  8  FIFO write byte
- tx_fifo_full  in  1  FIFO full flag
- tx_fifo_usedw  in  USEDW_W  FIFO fill level
- busy  out  1  high in SEND and GAP
- frame_cnt  out  16  frames completed, wraps
- drop_cnt  out  16  measurements overwritten before being sent, saturates at 16'hFFFF

## Operation
- Frame layout (FRAME_LEN = 12 bytes): HDR0, HDR1, seq, period[31:24..7:0], width[31:24..7:0], cksum.
- Period and width are sent big-endian.
- cksum is the sum mod 256 of bytes 2..10 (seq plus the 8 data bytes).
- seq starts at 0 after reset. It increments after each completed frame and wraps from 255 to 0.
- Pending buffer: on meas_valid, period and width are latched and the pending flag is set.
  - If meas_valid arrives while pending is already set, the new values overwrite the old ones and drop_cnt increments.
  - meas_valid is captured regardless of ena.
- States:
  - IDLE → SEND when pending && ena && tx_fifo_usedw <= FIFO_DEPTH-FRAME_LEN.
    - On this transition the pending values are copied into the shadow registers and pending clears.
    - If meas_valid arrives in the same cycle, it becomes the new pending value and no drop is counted.
  - SEND: one byte per cycle, index 0..FRAME_LEN-1.
    - If tx_fifo_full is high, wen is held low and the index holds. This is a safety stall only; the start check normally prevents it.
    - After the last byte is written, go to GAP.
  - GAP: one cycle, so usedw can settle, then IDLE.
    - frame_cnt and seq increment on entry to GAP.
- ena falling during SEND: the current frame completes. No new frame starts until ena is high again.
- Reset values: all outputs 0; state IDLE; pending 0; seq 0.
- Reset asserted mid-frame aborts the frame immediately. The partial frame already in the FIFO is the consumer's responsibility.

## Timing
- meas_valid in cycle T (IDLE, FIFO has room): pending is set at T+1, SEND is entered at T+2, first wen at T+2.
- Bytes are written in cycles T+2..T+13, contiguous when no stall occurs. GAP is T+14; IDLE is T+15.
- Minimum frame-to-frame spacing: 14 cycles.
- tx_fifo_wen and tx_fifo_wdata are registered. wdata is valid only while wen is high.
- Each full-flag stall cycle adds exactly one cycle of latency.

## Configuration
- Macro PULSE_REPORT_CKSUM_EN.
  - Defined: the cksum byte is appended and FRAME_LEN = 12.
  - Undefined: no cksum byte, FRAME_LEN = 11, and all timing shortens by one cycle.

## Structure
- Shared package pulse_acq_pkg holds:
  - HDR defaults
  - the FRAME_LEN constant (depends on the macro)
  - the state enum (IDLE, SEND, GAP)
  - byte index width
- One sub-module, pulse_frame_byte_sel: combinational mapping of byte index, seq, shadow period/width and running cksum to the output byte.
- The cksum accumulator stays in the top module. It is cleared on entry to SEND and accumulates bytes 2..10 as they are sent.

## Test plan
- Single measurement: period=32'h00989680, width=32'h004C4B40, usedw=0.
  - Expect bytes A5 5A 00 00 98 96 80 00 4C 4B 40 85 on 12 consecutive wen cycles starting at T+2.
  - Expect frame_cnt=1.
- Back-to-back: three meas_valid pulses 2 cycles apart, starting in IDLE.
  - First is sent; second is overwritten by the third, so drop_cnt=1.
  - Second frame carries the third measurement's values with seq=01.
- FIFO near full: usedw=FIFO_DEPTH-11 with pending set.
  - No start; wen stays 0.
  - Drop usedw to FIFO_DEPTH-12: frame starts the next cycle.
- Full stall: assert tx_fifo_full for 3 cycles at byte index 5.
  - Index holds and no wen during the stall; frame completes 3 cycles later, with the bytes unchanged.
- ena/reset: deassert ena mid-frame, then raise meas_valid.
  - Frame completes; the next frame waits until ena=1.
  - Assert rst mid-frame: wen=0 immediately, frame_cnt=0, seq restarts at 00.
- Macro undefined: repeat the first scenario.
  - Expect 11 bytes ending in 40; GAP at T+13.
